// File: rtl/key_irq_dev.sv
// key_irq_dev: bridge-side responder for the user keys.
// Each key pin is synchronised and debounced. Edges of the debounced level
// are latched into a pending register. An interrupt level is raised for any
// pending key whose interrupt is enabled. Registers are word-addressed through
// Addr[1:0].
module key_irq_dev #(
    parameter int NKEY           = 8,
    parameter int DB_CNT         = 250000,
    parameter int CNT_W          = 18,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [29:0]     Addr,
    input  logic            WE,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    input  logic [NKEY-1:0] user_key,
    output logic            IRQ
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CNT - 1);
    localparam logic [NKEY-1:0]  KEY_INV = {NKEY{KEY_ACTIVE_LOW}};

    localparam logic [1:0] A_STATE = 2'd0;
    localparam logic [1:0] A_PEND  = 2'd1;
    localparam logic [1:0] A_MASK  = 2'd2;
    localparam logic [1:0] A_CTRL  = 2'd3;

    logic [NKEY-1:0]  sync_p0;
    logic [NKEY-1:0]  sync_p1;
    logic [NKEY-1:0]  stable;
    logic [CNT_W-1:0] cnt [NKEY];
    logic [NKEY-1:0]  pend;
    logic [NKEY-1:0]  ie;
    logic [NKEY-1:0]  rise_en;
    logic [NKEY-1:0]  fall_en;

    logic [NKEY-1:0]  accept;
    logic [NKEY-1:0]  edge_set;
    logic [NKEY-1:0]  pend_clr;
    logic             wr_pend;
    logic             wr_mask;
    logic             wr_ctrl;

    // Only the word offset is decoded; the bridge has already qualified the hit.
    logic unused_bits;
    assign unused_bits = ^{Addr[29:2], Din};

    assign wr_pend = WE && (Addr[1:0] == A_PEND);
    assign wr_mask = WE && (Addr[1:0] == A_MASK);
    assign wr_ctrl = WE && (Addr[1:0] == A_CTRL);

    // Keys whose synchronised level has held long enough to be accepted this cycle.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NKEY; i++) begin
            accept[i] = (sync_p1[i] != stable[i]) && (cnt[i] == CNT_MAX);
        end
    end

    // An accepted change is a rising edge if the new level is 1, falling otherwise.
    assign edge_set = (accept & sync_p1 & rise_en) | (accept & ~sync_p1 & fall_en);
    assign pend_clr = wr_pend ? Din[NKEY-1:0] : '0;

    // Two-flop synchroniser, pins normalised so that 1 means pressed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= user_key ^ KEY_INV;
            sync_p1 <= sync_p0;
        end
    end

    // Per-key debounce: the level must disagree with stable for DB_CNT cycles in a row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= '0;
            for (int i = 0; i < NKEY; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NKEY; i++) begin
                if (sync_p1[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync_p1[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Pending bits: a new edge takes priority over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~pend_clr) | edge_set;
        end
    end

    // Software-writable enables for interrupts and edge selection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie      <= '0;
            rise_en <= '0;
            fall_en <= '0;
        end else begin
            if (wr_mask) begin
                ie <= Din[NKEY-1:0];
            end
            if (wr_ctrl) begin
                rise_en <= Din[NKEY-1:0];
                fall_en <= Din[16 +: NKEY];
            end
        end
    end

    // Read mux straight from the registers; unused bits read as zero.
    always_comb begin
        Dout = '0;
        case (Addr[1:0])
            A_STATE: Dout = 32'(stable);
            A_PEND:  Dout = 32'(pend);
            A_MASK:  Dout = 32'(ie);
            A_CTRL:  Dout = {16'(fall_en), 16'(rise_en)};
            default: Dout = '0;
        endcase
    end

    assign IRQ = |(pend & ie);

endmodule

// File: tb/tb_key_irq_dev.sv
// tb_key_irq_dev: directed bench for key_irq_dev with a short debounce window.
module tb_key_irq_dev;

    localparam int NKEY = 8;

    logic            clk;
    logic            reset;
    logic [29:0]     Addr;
    logic            WE;
    logic [31:0]     Din;
    logic [31:0]     Dout;
    logic [NKEY-1:0] user_key;
    logic            IRQ;

    int nvec;
    int nerr;

    key_irq_dev #(
        .NKEY(NKEY),
        .DB_CNT(4),
        .CNT_W(3),
        .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Addr(Addr),
        .WE(WE),
        .Din(Din),
        .Dout(Dout),
        .user_key(user_key),
        .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [1:0]  raddr;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [9];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = {28'b0, a};
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE  = 1'b0;
        Din = '0;
    endtask

    task automatic chk_reg(input string nm, input logic [1:0] a, input logic [31:0] exp);
        Addr = {28'b0, a};
        #1;
        nvec++;
        if (Dout !== exp) begin
            nerr++;
            $display("FAIL %s: Dout=%h expected %h", nm, Dout, exp);
        end
    endtask

    task automatic chk_irq(input string nm, input logic exp);
        #1;
        nvec++;
        if (IRQ !== exp) begin
            nerr++;
            $display("FAIL %s: IRQ=%b expected %b", nm, IRQ, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nvec = 0;
        nerr = 0;

        //            we    addr  din            raddr exp            irq
        tbl[0] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'h0000_00FF, 1'b0};
        tbl[1] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'h00FF_00FF, 1'b0};
        tbl[2] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 2'd0, 32'h0000_0000, 1'b0};
        tbl[3] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'h0000_0000, 1'b0};
        tbl[4] = '{1'b1, 2'd3, 32'h1234_5678, 2'd3, 32'h0034_0078, 1'b0};
        tbl[5] = '{1'b0, 2'd0, 32'h0000_0000, 2'd2, 32'h0000_00FF, 1'b0};
        tbl[6] = '{1'b1, 2'd2, 32'h0000_01A5, 2'd2, 32'h0000_00A5, 1'b0};
        tbl[7] = '{1'b1, 2'd2, 32'h0000_0000, 2'd2, 32'h0000_0000, 1'b0};
        tbl[8] = '{1'b1, 2'd3, 32'h0000_0000, 2'd3, 32'h0000_0000, 1'b0};

        clk      = 1'b0;
        reset    = 1'b0;
        WE       = 1'b0;
        Addr     = '0;
        Din      = '0;
        user_key = NKEY'($urandom);

        // Reset with random keys
        step(3);
        user_key = NKEY'($urandom);
        step(1);
        chk_irq("rst_irq", 1'b0);
        chk_reg("rst_state", 2'd0, 32'h0);
        chk_reg("rst_pend", 2'd1, 32'h0);
        chk_reg("rst_mask", 2'd2, 32'h0);
        chk_reg("rst_ctrl", 2'd3, 32'h0);

        user_key = 8'hFF;
        step(1);
        reset = 1'b1;
        step(10);
        chk_reg("idle_state", 2'd0, 32'h0);

        // Register access table
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].we) begin
                wr(tbl[i].addr, tbl[i].din);
            end
            chk_reg($sformatf("vec%0d_dout", i), tbl[i].raddr, tbl[i].exp_dout);
            chk_irq($sformatf("vec%0d_irq", i), tbl[i].exp_irq);
        end

        // Glitch shorter than the debounce window
        wr(2'd3, 32'h0000_0001);
        wr(2'd2, 32'h0000_0001);
        user_key = 8'hFE;
        step(3);
        user_key = 8'hFF;
        step(10);
        chk_reg("glitch_state", 2'd0, 32'h0);
        chk_reg("glitch_pend", 2'd1, 32'h0);
        chk_irq("glitch_irq", 1'b0);

        // Clean press: stable exactly 6 cycles after the pin change
        user_key = 8'hFE;
        step(5);
        chk_reg("lat5_state", 2'd0, 32'h0);
        chk_reg("lat5_pend", 2'd1, 32'h0);
        chk_irq("lat5_irq", 1'b0);
        step(1);
        chk_reg("lat6_state", 2'd0, 32'h1);
        chk_reg("lat6_pend", 2'd1, 32'h1);
        chk_irq("lat6_irq", 1'b1);

        // W1C clears pend and IRQ
        wr(2'd1, 32'h0000_0001);
        chk_reg("w1c_pend", 2'd1, 32'h0);
        chk_irq("w1c_irq", 1'b0);

        // Release key0 with fall_en[0]=0: no pend
        user_key = 8'hFF;
        step(8);
        chk_reg("rel0_state", 2'd0, 32'h0);
        chk_reg("rel0_pend", 2'd1, 32'h0);

        // Falling edge on key7, masked
        wr(2'd3, 32'h0080_0000);
        wr(2'd2, 32'h0000_0000);
        user_key = 8'h7F;
        step(8);
        chk_reg("k7_press_state", 2'd0, 32'h80);
        chk_reg("k7_press_pend", 2'd1, 32'h0);
        user_key = 8'hFF;
        step(8);
        chk_reg("k7_rel_pend", 2'd1, 32'h80);
        chk_irq("k7_masked_irq", 1'b0);
        wr(2'd2, 32'h0000_0080);
        chk_irq("k7_unmask_irq", 1'b1);
        wr(2'd1, 32'h0000_0080);
        chk_reg("k7_w1c_pend", 2'd1, 32'h0);
        chk_irq("k7_w1c_irq", 1'b0);

        // Set-vs-clear race on bit0
        wr(2'd3, 32'h0000_0001);
        wr(2'd2, 32'h0000_0001);
        user_key = 8'hFE;
        step(8);
        user_key = 8'hFF;
        step(8);
        chk_reg("race_pre_pend", 2'd1, 32'h1);
        chk_irq("race_pre_irq", 1'b1);
        user_key = 8'hFE;
        step(5);
        chk_reg("race_pre_state", 2'd0, 32'h0);
        Addr = 30'd1;
        Din  = 32'h0000_0001;
        WE   = 1'b1;
        step(1);
        WE   = 1'b0;
        Din  = '0;
        chk_reg("race_state", 2'd0, 32'h1);
        chk_reg("race_pend", 2'd1, 32'h1);
        chk_irq("race_irq", 1'b1);

        // Disabling the interrupt drops IRQ but keeps pend
        wr(2'd2, 32'h0000_0000);
        chk_irq("ie_off_irq", 1'b0);
        chk_reg("ie_off_pend", 2'd1, 32'h1);
        wr(2'd1, 32'h0000_0001);
        chk_reg("race_w1c_pend", 2'd1, 32'h0);

        // Key held through a reset pulse mid-debounce
        user_key = 8'hFF;
        step(8);
        wr(2'd3, 32'h0000_0008);
        user_key = 8'hF7;
        step(4);
        reset = 1'b0;
        step(1);
        chk_reg("hold_rst_ctrl", 2'd3, 32'h0);
        chk_reg("hold_rst_pend", 2'd1, 32'h0);
        reset = 1'b1;
        wr(2'd3, 32'h0000_0008);
        step(4);
        chk_reg("hold5_state", 2'd0, 32'h0);
        chk_reg("hold5_pend", 2'd1, 32'h0);
        step(1);
        chk_reg("hold6_state", 2'd0, 32'h8);
        chk_reg("hold6_pend", 2'd1, 32'h8);
        chk_irq("hold6_irq", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
